// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame geometry, counter width
// and the keyboard command bytes used by both directions of the link.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SHIFT,
      ACK,
      WAIT_IDLE
   } state_t;

   localparam int FRAME_BITS = 10;
   localparam int CNT_W      = 21;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ECHO     = 8'hEE;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] RSP_ACK      = 8'hFA;

   // Data bits LSB first, then odd parity, then the stop bit.
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] b);
      return {1'b1, ~^b, b};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: two-flop synchronizer, FILTER_LEN-sample debounce and a
// one-cycle pulse on each filtered 1->0 transition.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic clrn,
   input  logic raw,
   output logic level,
   output logic fall
);

   localparam int FW = $clog2(FILTER_LEN + 1);

   logic          sync_p0;
   logic          sync_p1;
   logic [FW-1:0] cnt;

   // Idle PS/2 lines float high, so every stage resets to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
         level   <= 1'b1;
         cnt     <= '0;
         fall    <= 1'b0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         fall    <= 1'b0;
         if (sync_p1 == level) begin
            cnt <= '0;
         end else if (cnt == FW'(FILTER_LEN - 1)) begin
            level <= sync_p1;
            cnt   <= '0;
            fall  <= level;
         end else begin
            cnt <= cnt + FW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 sender: inhibits the clock, presents the start bit,
// shifts a 10-bit frame on device clock falls and checks the device ACK.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_HZ         = 100_000_000,
   parameter int INHIBIT_CYCLES = 10_000,
   parameter int SETUP_CYCLES   = 200,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       err
);

   if (CLK_HZ <= 0 || INHIBIT_CYCLES < 1 || SETUP_CYCLES < 1 ||
       TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= 2**CNT_W) begin : g_cfg_check
      $error("ps2_host_tx: parameter out of range for %0d-bit counters", CNT_W);
   end

   state_t                state;
   logic [FRAME_BITS-1:0] frame;
   logic [3:0]            bit_idx;
   logic [CNT_W-1:0]      phase_cnt;
   logic [CNT_W-1:0]      tmo_cnt;
   logic                  ack_ok;
   logic                  clk_level;
   logic                  clk_fall;
   logic                  data_level;
   logic                  data_fall_unused;
   logic                  tmo_expired;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk   (clk),
      .clrn  (clrn),
      .raw   (ps2_clk_in),
      .level (clk_level),
      .fall  (clk_fall)
   );

   // The data line's edge pulse has no role in the send direction.
   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
      .clk   (clk),
      .clrn  (clrn),
      .raw   (ps2_data_in),
      .level (data_level),
      .fall  (data_fall_unused)
   );

   assign tx_ready    = (state == IDLE);
   assign busy        = ~tx_ready;
   assign tmo_expired = (tmo_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (tx_valid && state == IDLE) frame <= build_frame(tx_data);
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state       <= IDLE;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         bit_idx     <= '0;
         phase_cnt   <= '0;
         tmo_cnt     <= '0;
         ack_ok      <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (state == SHIFT || state == ACK || state == WAIT_IDLE) tmo_cnt <= tmo_cnt + CNT_W'(1);
         case (state)
            IDLE: begin
               if (tx_valid) begin
                  state      <= INHIBIT;
                  ps2_clk_oe <= 1'b1;
                  phase_cnt  <= '0;
                  bit_idx    <= '0;
               end
            end
            INHIBIT: begin
               if (phase_cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                  state       <= REQ;
                  ps2_data_oe <= 1'b1;
                  phase_cnt   <= '0;
               end else begin
                  phase_cnt <= phase_cnt + CNT_W'(1);
               end
            end
            REQ: begin
               if (phase_cnt == CNT_W'(SETUP_CYCLES - 1)) begin
                  state      <= SHIFT;
                  ps2_clk_oe <= 1'b0;
                  tmo_cnt    <= '0;
               end else begin
                  phase_cnt <= phase_cnt + CNT_W'(1);
               end
            end
            // A clock fall takes priority over a timeout landing in the same cycle.
            SHIFT: begin
               if (clk_fall) begin
                  ps2_data_oe <= ~frame[bit_idx];
                  if (bit_idx == 4'(FRAME_BITS - 1)) state <= ACK;
                  else bit_idx <= bit_idx + 4'd1;
               end else if (tmo_expired) begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  err         <= 1'b1;
                  state       <= IDLE;
               end
            end
            ACK: begin
               if (clk_fall) begin
                  ack_ok <= ~data_level;
                  state  <= WAIT_IDLE;
               end else if (tmo_expired) begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  err         <= 1'b1;
                  state       <= IDLE;
               end
            end
            WAIT_IDLE: begin
               if (clk_level && data_level) begin
                  done  <= ack_ok;
                  err   <= ~ack_ok;
                  state <= IDLE;
               end else if (tmo_expired) begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  err         <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural keyboard on the open-drain lines,
// frames predicted from the byte with plain arithmetic.
module tb_ps2_host_tx;

   localparam int INH  = 100;
   localparam int SET  = 20;
   localparam int FIL  = 8;
   localparam int TMO  = 3000;
   localparam int HALF = 40;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, clk_oe, data_oe, busy, done, err;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       cline, dline;

   int n_checks = 0;
   int n_fail = 0;
   int n_done = 0;
   int n_err = 0;
   int n_both = 0;
   int n_clk_low = 0;

   assign cline = ~clk_oe & dev_clk;
   assign dline = ~data_oe & dev_data;

   always #5 clk = ~clk;

   ps2_host_tx #(
      .CLK_HZ         (100_000_000),
      .INHIBIT_CYCLES (INH),
      .SETUP_CYCLES   (SET),
      .FILTER_LEN     (FIL),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .clrn        (clrn),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .ps2_clk_in  (cline),
      .ps2_data_in (dline),
      .ps2_clk_oe  (clk_oe),
      .ps2_data_oe (data_oe),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always @(negedge clk) begin
      if (done) n_done++;
      if (err) n_err++;
      if (done && err) n_both++;
      if (clk_oe) n_clk_low++;
   end

   function automatic logic [9:0] model_frame(input logic [7:0] b);
      int ones;
      ones = $countones(b);
      return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check("clk_pull_after_accept", clk_oe, 1);
   endtask

   // Keyboard side: waits for the request, clocks 10 bits in, then ACKs or NACKs.
   task automatic device_rx(input bit ack, input bit glitch, input int abort_bit,
                            output logic [9:0] bits);
      int w;
      bits = '0;
      w = 0;
      while (!(clk_oe == 1'b0 && data_oe == 1'b1) && w < INH + SET + 50) begin
         @(negedge clk);
         w++;
      end
      check("request_seen", (clk_oe == 1'b0 && data_oe == 1'b1), 1);
      repeat (HALF) @(negedge clk);
      for (int k = 1; k <= 10; k++) begin
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         if (k == abort_bit) begin
            check("pre_reset_data_oe", data_oe, ~model_frame(tx_data) >> (k - 1) & 32'h1);
            #2 clrn = 1'b0;
            #1;
            check("reset_clk_oe", clk_oe, 0);
            check("reset_data_oe", data_oe, 0);
            check("reset_tx_ready", tx_ready, 1);
            dev_clk = 1'b1;
            repeat (4) @(negedge clk);
            clrn = 1'b1;
            repeat (4) @(negedge clk);
            return;
         end
         dev_clk = 1'b1;
         repeat (HALF / 2) @(negedge clk);
         bits[k-1] = dline;
         if (glitch && k == 4) begin
            dev_clk = 1'b0;
            repeat (3) @(negedge clk);
            dev_clk = 1'b1;
            repeat (HALF / 2 - 3) @(negedge clk);
         end else begin
            repeat (HALF / 2) @(negedge clk);
         end
      end
      if (ack) dev_data = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (ack) begin
         repeat (HALF / 2) @(negedge clk);
         dev_data = 1'b1;
      end
      w = 0;
      while (!(done || err) && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("end_latency", w, FIL + 3);
      @(negedge clk);
      check("tx_ready_next", tx_ready, 1);
      check("pulse_single", done | err, 0);
   endtask

   task automatic run_xfer(input logic [7:0] b, input bit ack, input bit glitch, input bit bp,
                           output logic [9:0] bits);
      int d0, e0, c0;
      d0 = n_done;
      e0 = n_err;
      c0 = n_clk_low;
      send(b);
      if (bp) begin
         tx_data  = 8'hFF;
         tx_valid = 1'b1;
         repeat (5) @(negedge clk);
         check("busy_under_backpressure", busy, 1);
         tx_valid = 1'b0;
         tx_data  = b;
      end
      device_rx(ack, glitch, 0, bits);
      repeat (2) @(negedge clk);
      check("frame", bits, model_frame(b));
      check("clk_low_len", n_clk_low - c0, INH + SET);
      check("done_count", n_done - d0, ack ? 1 : 0);
      check("err_count", n_err - e0, ack ? 0 : 1);
   endtask

   initial begin
      logic [9:0] bits;
      logic [7:0] b;
      int c;

      clrn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_clk_oe", clk_oe, 0);
      check("rst_data_oe", data_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_tx_ready", tx_ready, 1);
      clrn = 1'b1;
      repeat (3) @(negedge clk);

      run_xfer(ps2_pkg::CMD_SET_LEDS, 1'b1, 1'b0, 1'b0, bits);
      check("ed_frame_bits", bits, 10'h3ED);

      run_xfer(8'h01, 1'b1, 1'b0, 1'b0, bits);
      check("parity_01", bits[8], 0);
      run_xfer(8'hFF, 1'b1, 1'b0, 1'b0, bits);
      check("parity_ff", bits[8], 1);
      run_xfer(8'h00, 1'b1, 1'b0, 1'b0, bits);
      check("parity_00", bits[8], 1);

      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom_range(0, 255));
         run_xfer(b, 1'b1, 1'b0, 1'b0, bits);
      end

      b = 8'($urandom_range(0, 255));
      run_xfer(b, 1'b0, 1'b0, 1'b0, bits);

      // Silent keyboard: no clock ever arrives after release.
      b = 8'($urandom_range(0, 255));
      send(b);
      c = 0;
      while (!(clk_oe == 1'b0 && data_oe == 1'b1) && c < INH + SET + 50) begin
         @(negedge clk);
         c++;
      end
      check("silent_release", clk_oe, 0);
      c = 0;
      while (c < TMO + 100) begin
         @(negedge clk);
         c++;
         if (err) break;
      end
      check("timeout_len", c, TMO);
      check("timeout_no_done", done, 0);
      @(negedge clk);
      check("timeout_clk_oe", clk_oe, 0);
      check("timeout_data_oe", data_oe, 0);
      check("timeout_tx_ready", tx_ready, 1);

      send(ps2_pkg::CMD_SET_LEDS);
      device_rx(1'b1, 1'b0, 5, bits);
      run_xfer(ps2_pkg::CMD_SET_LEDS, 1'b1, 1'b0, 1'b0, bits);

      b = 8'($urandom_range(0, 254));
      run_xfer(b, 1'b1, 1'b1, 1'b1, bits);

      check("done_err_exclusive", n_both, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
